// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction fetch responder.
package imem_fetch_responder_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // One fetch response; used for pipeline stages and FIFO entries.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } fetch_rsp_t;

endpackage

// File: rtl/imem_fetch_responder_rsp_fifo.sv
// Small in-order response FIFO with flush; element type is a parameter so
// the data-memory responder can reuse it.
module rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0]
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output T                         o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;

  // Pops on an empty FIFO are ignored.
  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; flush takes priority over push/pop.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care once the count says empty.
  always_ff @(posedge CLK) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: credit-controlled fixed-latency read
// pipeline feeding an in-order response FIFO, with flush and loader port.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           ReqValid,
  output logic                           ReqReady,
  input  logic [31:0]                    ReqAddr,
  input  logic                           Flush,
  output logic                           RspValid,
  input  logic                           RspReady,
  output logic [31:0]                    RspInstr,
  output logic [31:0]                    RspAddr,
  output logic                           RspFault,
  input  logic                           LoadEn,
  input  logic [$clog2(DEPTH_WORDS)-1:0] LoadAddr,
  input  logic [31:0]                    LoadData,
  output logic                           Busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [LATENCY-1:0] r_stg_v;
  fetch_rsp_t       r_stg_d [LATENCY];

  logic             w_fault;
  logic [IDX_W-1:0] w_idx;
  logic             w_accept;
  fetch_rsp_t       w_rsp;
  fetch_rsp_t       w_head;
  logic [CNT_W-1:0] w_inflight;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_used;

  // Loader write; a fetch on the same edge still sees the old word.
  always_ff @(posedge CLK) begin
    if (LoadEn) r_mem[LoadAddr] <= LoadData;
  end

  // Request decode: faulting fetches use index 0 and return a NOP.
  always_comb begin
    w_fault   = (ReqAddr[1:0] != 2'b00) || (ReqAddr[31:2] >= 30'(DEPTH_WORDS));
    w_idx     = w_fault ? '0 : ReqAddr[IDX_W+1:2];
    w_rsp     = '0;
    w_rsp.instr = w_fault ? NOP_INSTR : r_mem[w_idx];
    w_rsp.addr  = ReqAddr;
    w_rsp.fault = w_fault;
  end

  // Count valid pipeline stages for credit and busy tracking.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < int'(LATENCY); k++) begin
      w_inflight = w_inflight + CNT_W'(r_stg_v[k]);
    end
  end

  assign w_used   = {1'b0, w_inflight} + {1'b0, w_count};
  assign ReqReady = !Reset && !Flush && (w_used < (CNT_W+1)'(RSP_DEPTH));
  assign w_accept = ReqValid && ReqReady;

  // Read pipeline: stage 0 captures the synchronous read, later stages shift.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_stg_v <= '0;
      for (int k = 0; k < int'(LATENCY); k++) r_stg_d[k] <= '0;
    end else begin
      if (Flush) r_stg_v <= '0;
      else begin
        r_stg_v[0] <= w_accept;
        for (int k = 1; k < int'(LATENCY); k++) r_stg_v[k] <= r_stg_v[k-1];
      end
      if (w_accept) r_stg_d[0] <= w_rsp;
      for (int k = 1; k < int'(LATENCY); k++) r_stg_d[k] <= r_stg_d[k-1];
    end
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (fetch_rsp_t)
  ) u_rsp_fifo (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_push  (r_stg_v[LATENCY-1]),
    .i_data  (r_stg_d[LATENCY-1]),
    .i_pop   (RspValid && RspReady),
    .i_flush (Flush),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Response outputs are zero whenever nothing is queued.
  assign RspValid = (w_count != '0);
  assign RspInstr = RspValid ? w_head.instr : '0;
  assign RspAddr  = RspValid ? w_head.addr  : '0;
  assign RspFault = RspValid ? w_head.fault : 1'b0;
  assign Busy     = (w_inflight != '0) || (w_count != '0);

endmodule
